// File: rtl/vga_layer_arbiter_pkg.sv
// Shared types for the VGA layer arbiter: chain pixel struct, 4/4/4 colour, FSM states.
// Helper multi_hot() flags two or more set bits (layer overlap).
package vga_layer_arbiter_pkg;

    localparam int unsigned MAX_LAYERS = 8;
    localparam int unsigned COORD_W    = 11;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb12_t;

    typedef struct packed {
        logic [COORD_W-1:0] pxl_x;
        logic [COORD_W-1:0] pxl_y;
        logic [3:0]         red;
        logic [3:0]         green;
        logic [3:0]         blue;
        logic               en;
    } vga_pixel_t;

    typedef struct packed {
        vga_pixel_t t;
    } vga_t;

    typedef enum logic [1:0] {
        WAIT,
        ACTIVE,
        PUBLISH
    } arb_state_e;

    // v & (v-1) clears the lowest set bit; anything left means >= 2 bits set.
    function automatic logic multi_hot(input logic [MAX_LAYERS-1:0] v);
        logic [MAX_LAYERS-1:0] one;
        one = {{(MAX_LAYERS-1){1'b0}}, 1'b1};
        return (v & (v - one)) != '0;
    endfunction

endpackage

// File: rtl/vga_layer_arbiter_prio_enc.sv
// Combinational lowest-index priority encoder: one-hot grant plus any-request flag.
// Shared with the other chain mixers.
module vga_layer_arbiter_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] sel,
    output logic         any
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/vga_layer_arbiter.sv
// Per-pixel layer arbiter for the VGA chain: highest-priority masked layer wins the colour slot.
// Define LAYER_COLLISION_EN to build the per-frame collision accumulator and valid/ack handshake.
module vga_layer_arbiter
    import vga_layer_arbiter_pkg::*;
#(
    parameter int unsigned N_LAYERS = 4,
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  vga_t                  vga_chain_in,
    output vga_t                  vga_chain_out,
    input  logic [N_LAYERS-1:0]   layer_en,
    input  rgb12_t [N_LAYERS-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]   layer_mask,
    output logic                  frame_start,
    output logic [N_LAYERS-1:0]   coll_flags,
    output logic                  coll_valid,
    output logic                  coll_overrun,
    input  logic                  coll_ack
);

    localparam logic [COORD_W-1:0] X_END  = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] Y_END  = COORD_W'(HEIGHT);

    arb_state_e          state_q;
    logic [N_LAYERS-1:0] active_mask;
    logic [N_LAYERS-1:0] mask_eff;
    logic [N_LAYERS-1:0] req;
    logic [N_LAYERS-1:0] sel;
    logic                any;
    logic                frame_start_pix;
    logic                visible;
    logic [11:0]         win_rgb;
    vga_pixel_t          pix_d;

    assign frame_start_pix = (vga_chain_in.t.pxl_x == '0) && (vga_chain_in.t.pxl_y == '0);
    assign visible         = (vga_chain_in.t.pxl_x < X_END) && (vga_chain_in.t.pxl_y < Y_END);

    // The frame-start pixel already uses the freshly sampled mask.
    assign mask_eff = frame_start_pix ? layer_mask : active_mask;
    assign req      = layer_en & mask_eff & {N_LAYERS{visible}};

    vga_layer_arbiter_prio_enc #(
        .N (N_LAYERS)
    ) u_prio_enc (
        .req (req),
        .sel (sel),
        .any (any)
    );

    always_comb begin
        win_rgb = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (sel[i]) win_rgb = win_rgb | layer_rgb[i];
        end
    end

    always_comb begin
        pix_d = vga_chain_in.t;
        if (any) begin
            pix_d.red   = win_rgb[11:8];
            pix_d.green = win_rgb[7:4];
            pix_d.blue  = win_rgb[3:0];
            pix_d.en    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vga_chain_out <= '0;
            frame_start   <= 1'b0;
        end else begin
            vga_chain_out.t <= pix_d;
            frame_start     <= frame_start_pix;
        end
    end

`ifdef LAYER_COLLISION_EN
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    logic                  frame_end_pix;
    logic [MAX_LAYERS-1:0] req_ext;
    logic [N_LAYERS-1:0]   coll_here;
    logic [N_LAYERS-1:0]   acc_q;

    assign frame_end_pix = (vga_chain_in.t.pxl_x == X_LAST) && (vga_chain_in.t.pxl_y == Y_LAST);

    always_comb begin
        req_ext               = '0;
        req_ext[N_LAYERS-1:0] = req;
    end

    // Blanking pixels have req forced to 0, so they never contribute.
    assign coll_here = multi_hot(req_ext) ? req : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= WAIT;
            active_mask  <= '1;
            acc_q        <= '0;
            coll_flags   <= '0;
            coll_valid   <= 1'b0;
            coll_overrun <= 1'b0;
        end else begin
            if (frame_start_pix) active_mask <= layer_mask;

            unique case (state_q)
                WAIT: begin
                    if (frame_start_pix) begin
                        state_q <= ACTIVE;
                        acc_q   <= coll_here;
                    end
                end
                ACTIVE: begin
                    if (frame_start_pix) begin
                        acc_q <= coll_here;
                    end else begin
                        acc_q <= acc_q | coll_here;
                        if (frame_end_pix) state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    state_q <= frame_start_pix ? ACTIVE : WAIT;
                    if (frame_start_pix) acc_q <= coll_here;
                end
                default: state_q <= WAIT;
            endcase

            // A publish coinciding with an ack keeps the new data and counts as consumed.
            if (state_q == PUBLISH) begin
                coll_flags <= acc_q;
                coll_valid <= 1'b1;
                if (coll_valid && coll_ack) begin
                    coll_overrun <= 1'b0;
                end else if (coll_valid) begin
                    coll_overrun <= 1'b1;
                end
            end else if (coll_ack && coll_valid) begin
                coll_valid   <= 1'b0;
                coll_overrun <= 1'b0;
            end
        end
    end
`else
    logic unused_ack;

    assign unused_ack   = coll_ack;
    assign coll_flags   = '0;
    assign coll_valid   = 1'b0;
    assign coll_overrun = 1'b0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= WAIT;
            active_mask <= '1;
        end else begin
            if (frame_start_pix) active_mask <= layer_mask;
            unique case (state_q)
                WAIT:    if (frame_start_pix) state_q <= ACTIVE;
                default: state_q <= ACTIVE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Self-checking bench for vga_layer_arbiter: vector table, directed corner sequences and
// randomized pixels against a frame-level reference model.
module tb_vga_layer_arbiter;
    import vga_layer_arbiter_pkg::*;

    localparam int unsigned NL = 4;
`ifdef LAYER_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    vga_t             vin;
    vga_t             vout;
    logic [NL-1:0]    len;
    rgb12_t [NL-1:0]  lrgb;
    logic [NL-1:0]    lmask;
    logic             fs;
    logic [NL-1:0]    cflags;
    logic             cvalid;
    logic             covr;
    logic             cack;

    always #5 clk = ~clk;

    vga_layer_arbiter #(
        .N_LAYERS (NL),
        .WIDTH    (640),
        .HEIGHT   (480)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .vga_chain_in  (vin),
        .vga_chain_out (vout),
        .layer_en      (len),
        .layer_rgb     (lrgb),
        .layer_mask    (lmask),
        .frame_start   (fs),
        .coll_flags    (cflags),
        .coll_valid    (cvalid),
        .coll_overrun  (covr),
        .coll_ack      (cack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    vga_pixel_t    m_out;
    logic          m_fs;
    logic [NL-1:0] m_flags;
    logic [NL-1:0] m_mask;
    logic [NL-1:0] m_acc;
    logic          m_valid;
    logic          m_ovr;
    logic          m_in_frame;
    logic          m_pub;

    typedef struct {
        logic [10:0]   x;
        logic [10:0]   y;
        logic [11:0]   in_rgb;
        logic          in_en;
        logic [NL-1:0] le;
        logic [11:0]   exp_rgb;
        logic          exp_en;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out      = '0;
        m_fs       = 1'b0;
        m_flags    = '0;
        m_mask     = '1;
        m_acc      = '0;
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_in_frame = 1'b0;
        m_pub      = 1'b0;
    endtask

    // Frame-level rules: winner is the lowest enabled masked layer; overlaps OR into the
    // frame's flag set, which is handed over one cycle after the frame's last pixel.
    task automatic model_step();
        logic          start;
        logic          fend;
        logic          vis;
        logic [NL-1:0] mask;
        logic [NL-1:0] req;
        logic [NL-1:0] coll;
        int            win;
        start = (vin.t.pxl_x == 11'd0) && (vin.t.pxl_y == 11'd0);
        fend  = (vin.t.pxl_x == 11'd639) && (vin.t.pxl_y == 11'd479);
        vis   = (vin.t.pxl_x < 11'd640) && (vin.t.pxl_y < 11'd480);
        mask  = start ? lmask : m_mask;
        req   = vis ? (len & mask) : '0;
        win   = -1;
        for (int i = NL - 1; i >= 0; i--) if (req[i]) win = i;
        m_out = vin.t;
        if (win >= 0) begin
            m_out.red   = lrgb[win].red;
            m_out.green = lrgb[win].green;
            m_out.blue  = lrgb[win].blue;
            m_out.en    = 1'b1;
        end
        m_fs = start;
        coll = ($countones(req) >= 2) ? req : '0;
        if (m_pub) begin
            m_flags = m_acc;
            if (m_valid && cack) m_ovr = 1'b0;
            else if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
        end else if (cack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        m_pub = 1'b0;
        if (start) begin
            m_acc      = coll;
            m_in_frame = 1'b1;
        end else if (m_in_frame) begin
            m_acc = m_acc | coll;
            if (fend) begin
                m_in_frame = 1'b0;
                m_pub      = 1'b1;
            end
        end
        m_mask = mask;
    endtask

    task automatic compare_all();
        check("pixel", 64'(vout.t), 64'(m_out));
        check("frame_start", 64'(fs), 64'(m_fs));
        check("coll_flags", 64'(cflags), 64'(COLL ? m_flags : 4'h0));
        check("coll_valid", 64'(cvalid), 64'(COLL ? m_valid : 1'b0));
        check("coll_overrun", 64'(covr), 64'(COLL ? m_ovr : 1'b0));
    endtask

    task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic [11:0] rgb,
                         input logic en, input logic [NL-1:0] le, input logic [NL-1:0] lm,
                         input logic ack);
        vin.t.pxl_x = x;
        vin.t.pxl_y = y;
        vin.t.red   = rgb[11:8];
        vin.t.green = rgb[7:4];
        vin.t.blue  = rgb[3:0];
        vin.t.en    = en;
        len         = le;
        lmask       = lm;
        cack        = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic reset_pulse();
        resetN = 1'b0;
        #2;
        model_reset();
        check("rst_pixel", 64'(vout.t), 64'd0);
        check("rst_frame_start", 64'(fs), 64'd0);
        check("rst_flags", 64'(cflags), 64'd0);
        check("rst_valid", 64'(cvalid), 64'd0);
        check("rst_overrun", 64'(covr), 64'd0);
        @(posedge clk);
        #1;
        compare_all();
        #2;
        resetN = 1'b1;
    endtask

    function automatic logic [11:0] out_rgb();
        return {vout.t.red, vout.t.green, vout.t.blue};
    endfunction

    initial begin
        logic [10:0] rx;
        logic [10:0] ry;
        int          sel;

        vecs[0] = '{11'd5,   11'd5, 12'hFFF, 1'b1, 4'b0000, 12'hFFF, 1'b1};
        vecs[1] = '{11'd5,   11'd6, 12'h000, 1'b0, 4'b0110, 12'hF00, 1'b1};
        vecs[2] = '{11'd6,   11'd6, 12'h123, 1'b0, 4'b1000, 12'h00F, 1'b1};
        vecs[3] = '{11'd7,   11'd6, 12'h000, 1'b0, 4'b0001, 12'hABC, 1'b1};
        vecs[4] = '{11'd8,   11'd6, 12'h456, 1'b1, 4'b1111, 12'hABC, 1'b1};
        vecs[5] = '{11'd700, 11'd5, 12'h555, 1'b0, 4'b0001, 12'h555, 1'b0};
        vecs[6] = '{11'd9,   11'd9, 12'h000, 1'b0, 4'b0000, 12'h000, 1'b0};

        vin     = '0;
        len     = '0;
        lmask   = 4'hF;
        cack    = 1'b0;
        lrgb[0] = 12'hABC;
        lrgb[1] = 12'hF00;
        lrgb[2] = 12'h0F0;
        lrgb[3] = 12'h00F;
        drive(11'd20, 11'd20, 12'h000, 1'b0, 4'b0000, 4'hF, 1'b0);
        reset_pulse();

        // Arbitration vectors, still in WAIT with the reset mask
        foreach (vecs[i]) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].in_rgb, vecs[i].in_en, vecs[i].le, 4'hF, 1'b0);
            tick();
            check($sformatf("tbl%0d_rgb", i), 64'(out_rgb()), 64'(vecs[i].exp_rgb));
            check($sformatf("tbl%0d_en", i), 64'(vout.t.en), 64'(vecs[i].exp_en));
        end

        // Overlap and frame end seen while waiting: nothing is published
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0110, 4'hF, 1'b0);
        tick();
        drive(11'd50, 11'd50, 12'h000, 1'b0, 4'b0000, 4'hF, 1'b0);
        tick();
        check("wait_no_publish", 64'(cvalid), 64'd0);

        // Mask changes only at the frame-start pixel
        drive(11'd100, 11'd100, 12'h000, 1'b0, 4'b0001, 4'b1110, 1'b0);
        tick();
        check("mask_midframe_rgb", 64'(out_rgb()), 64'hABC);
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0011, 4'b1110, 1'b0);
        tick();
        check("mask_start_rgb", 64'(out_rgb()), 64'hF00);
        check("mask_start_pulse", 64'(fs), 64'd1);
        drive(11'd1, 11'd0, 12'h123, 1'b0, 4'b0001, 4'b1110, 1'b0);
        tick();
        check("mask_l0_ignored", 64'({out_rgb(), vout.t.en}), 64'({12'h123, 1'b0}));
        check("frame_start_one_cycle", 64'(fs), 64'd0);

        // Collision publish timing
        drive(11'd10, 11'd20, 12'h000, 1'b0, 4'b1010, 4'b1110, 1'b0);
        tick();
        check("coll_pixel_rgb", 64'(out_rgb()), 64'hF00);
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0);
        tick();
        check("pub_not_yet", 64'(cvalid), 64'd0);
        drive(11'd700, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0);
        tick();
        check("pub_flags", 64'(cflags), 64'(COLL ? 4'b1010 : 4'b0000));
        check("pub_valid", 64'(cvalid), 64'(COLL));

        // Second frame without ack -> overrun
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd3, 11'd3, 12'h000, 1'b0, 4'b0110, 4'b1110, 1'b0); tick();
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd640, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        check("ovr_flags", 64'(cflags), 64'(COLL ? 4'b0110 : 4'b0000));
        check("ovr_set", 64'(covr), 64'(COLL));
        drive(11'd640, 11'd1, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b1); tick();
        check("ack_clears_valid", 64'(cvalid), 64'd0);
        check("ack_clears_ovr", 64'(covr), 64'd0);

        // Ack coincident with publish: new data kept, no overrun
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd4, 11'd4, 12'h000, 1'b0, 4'b1100, 4'b1110, 1'b0); tick();
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd640, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        check("sim_first_valid", 64'(cvalid), 64'(COLL));
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd5, 11'd5, 12'h000, 1'b0, 4'b0110, 4'b1110, 1'b0); tick();
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd640, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b1); tick();
        check("sim_valid", 64'(cvalid), 64'(COLL));
        check("sim_no_ovr", 64'(covr), 64'd0);
        check("sim_flags", 64'(cflags), 64'(COLL ? 4'b0110 : 4'b0000));
        drive(11'd640, 11'd1, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b1); tick();

        // Reset mid-frame drops the pending overlap
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd5, 11'd5, 12'h000, 1'b0, 4'b1010, 4'b1110, 1'b0); tick();
        drive(11'd300, 11'd200, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        reset_pulse();
        drive(11'd300, 11'd201, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd0, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd7, 11'd7, 12'h000, 1'b0, 4'b1100, 4'b1110, 1'b0); tick();
        drive(11'd639, 11'd479, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        drive(11'd640, 11'd0, 12'h000, 1'b0, 4'b0000, 4'b1110, 1'b0); tick();
        check("post_rst_flags", 64'(cflags), 64'(COLL ? 4'b1100 : 4'b0000));
        check("post_rst_valid", 64'(cvalid), 64'(COLL));

        // Randomized pixels against the model
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                rx = 11'd0;
                ry = 11'd0;
            end else if (sel == 1) begin
                rx = 11'd639;
                ry = 11'd479;
            end else if (sel == 2) begin
                rx = 11'($urandom_range(640, 799));
                ry = 11'($urandom_range(0, 524));
            end else begin
                rx = 11'($urandom_range(1, 639));
                ry = 11'($urandom_range(0, 479));
            end
            for (int i = 0; i < int'(NL); i++) lrgb[i] = 12'($urandom);
            drive(rx, ry, 12'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_layer_arbiter.md
# vga_layer_arbiter

Per-pixel arbiter that shares the VGA chain's colour slot among N_LAYERS sprite and overlay drawers. Examples of drawers are ships, asteroids, bullets and score. On each pixel it selects the highest-priority active layer, gated by a per-frame layer mask, and drives that layer's colour onto the chain. If no layer is active, the upstream pixel passes through unchanged. It optionally accumulates per-layer overlap (collision) flags across a frame and hands them to game logic through a valid/ack handshake. It sits in the chain directly downstream of the star-field background stage.

## Interface
- N_LAYERS, 4: number of layer requesters, 2..8; index 0 has the highest priority.
- WIDTH, 640: visible pixels per line.
- HEIGHT, 480: visible lines per frame.
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- vga_chain_in  vga.in  struct  upstream chain pixel; uses t.pxl_x, t.pxl_y, t.red/green/blue (4 b each), t.en.
- vga_chain_out  vga.out  struct  downstream chain pixel, registered.
- layer_en  in  N_LAYERS  layer i has a pixel here; cycle-aligned with vga_chain_in.
- layer_rgb  in  N_LAYERS×12  {r,g,b} per layer, 4 b each, aligned with layer_en.
- layer_mask  in  N_LAYERS  layer enable mask; sampled only at frame start.
- frame_start  out  1  one-cycle pulse, registered, when (0,0) is seen on the input.
- coll_flags  out  N_LAYERS  per-layer collision flags of the last completed frame.
- coll_valid  out  1  coll_flags holds unread data.
- coll_overrun  out  1  a frame's flags were overwritten before being acked.
- coll_ack  in  1  one-cycle strobe that consumes coll_flags.

## Operation
- Frame start is in_pxl_x==0 && in_pxl_y==0. On that cycle:
  - active_mask <= layer_mask.
  - The live collision accumulator clears.
  - The state machine enters ACTIVE.
- Frame end is in_pxl_x==WIDTH-1 && in_pxl_y==HEIGHT-1.
- State machine:
  - WAIT: after reset; no collision accumulation; arbitration still runs with active_mask. On frame start, go to ACTIVE.
  - ACTIVE: accumulate collisions. On frame end, go to PUBLISH.
  - PUBLISH: one cycle; coll_flags <= live accumulator; coll_valid <= 1. Go to WAIT.
- Arbitration:
  - req = layer_en & active_mask; sel = lowest set index of req.
  - If req != 0: out.t = in.t with red/green/blue = layer_rgb[sel] and en = 1.
  - Else: out.t = in.t unchanged.
  - active_mask takes effect from the frame-start pixel itself: the mask used on that pixel is the newly sampled layer_mask.
- Collision rule: when popcount(req) >= 2 in ACTIVE, every set bit of req ORs into the live accumulator. Masked-off layers never collide.
- Handshake:
  - coll_ack with coll_valid=1 clears coll_valid and coll_overrun.
  - coll_ack with coll_valid=0 has no effect.
  - PUBLISH while coll_valid=1 sets coll_overrun and overwrites coll_flags.
  - PUBLISH and coll_ack in the same cycle: new data wins; coll_valid stays 1; coll_overrun is not set.
- Pixel coordinates beyond WIDTH/HEIGHT (blanking): pass through; no accumulation.

## Timing
- Pixel path latency is 1 clk, from vga_chain_in/layer_* to vga_chain_out.
- frame_start pulses 1 clk after (0,0) is presented on the input.
- coll_valid rises 2 clk after the frame-end pixel is presented (the PUBLISH register stage).
- Reset values:
  - vga_chain_out.t all zero (rgb 0, en 0).
  - frame_start 0, coll_flags 0, coll_valid 0, coll_overrun 0.
  - active_mask all ones; state WAIT; live accumulator 0.
- Reset asserted mid-frame drops all pending flags. The block resumes accumulating only at the next (0,0).

## Configuration
- LAYER_COLLISION_EN defined: the accumulator, PUBLISH state and handshake are built as described.
- LAYER_COLLISION_EN undefined: coll_flags, coll_valid and coll_overrun are tied to 0 and coll_ack is ignored. The state machine reduces to WAIT/ACTIVE for mask sampling only. Arbitration and latency are unchanged.

## Structure
- The shared package holds:
  - typedef rgb12_t as the packed 4/4/4 colour struct.
  - typedef arb_state_e with values WAIT, ACTIVE, PUBLISH.
  - Constant MAX_LAYERS = 8.
- One sub-module, prio_enc: combinational lowest-index priority encoder producing a one-hot sel and an any flag. It is reused by other chain mixers.

## Test plan
- Pass-through: layer_en=0, input rgb 0xF,0xF,0xF with en=1 -> same pixel on the output 1 clk later.
- Priority: layer_en=4'b0110, rgb1=0xF00, rgb2=0x0F0 -> output 0xF00, en=1. No collision is recorded while in WAIT.
- Mask sampling:
  - Set layer_mask=4'b1110 mid-frame -> layer 0 still wins until the next (0,0).
  - From (0,0) on, layer 0 is ignored.
- Collision publish: layers 1 and 3 overlap at (10,20) within a frame -> 2 clk after pixel (639,479), coll_flags=4'b1010 and coll_valid=1.
- Overrun and simultaneity:
  - No ack over two collision frames -> coll_overrun=1.
  - coll_ack coincident with PUBLISH -> coll_valid stays 1 and coll_overrun stays 0.
- Reset mid-frame: pulse resetN low at (300,200) -> all outputs 0. The next frame's flags reflect only that frame.
